// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle between the instruction prefetch queue, the instruction ROM and
// the LEGv8 multicycle control unit. The master modport belongs to the queue
// and the slave modport to its environment. Defining PREFETCH_STATS_EN adds
// the flush_cnt and starve_cnt statistics outputs.
interface instr_prefetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
);
    logic                     rom_req;
    logic [ADDR_W-1:0]        rom_addr;
    logic [31:0]              rom_data;
    logic                     fetch;
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic [31:0]              instr;
    logic [ADDR_W-1:0]        instr_pc;
    logic                     instr_valid;
    logic [$clog2(DEPTH):0]   count;
`ifdef PREFETCH_STATS_EN
    logic [15:0]              flush_cnt;
    logic [15:0]              starve_cnt;

    modport master (
        output rom_req, rom_addr, instr, instr_pc, instr_valid, count,
        output flush_cnt, starve_cnt,
        input  rom_data, fetch, redirect, redirect_pc
    );
    modport slave (
        input  rom_req, rom_addr, instr, instr_pc, instr_valid, count,
        input  flush_cnt, starve_cnt,
        output rom_data, fetch, redirect, redirect_pc
    );
`else
    modport master (
        output rom_req, rom_addr, instr, instr_pc, instr_valid, count,
        input  rom_data, fetch, redirect, redirect_pc
    );
    modport slave (
        input  rom_req, rom_addr, instr, instr_pc, instr_valid, count,
        output rom_data, fetch, redirect, redirect_pc
    );
`endif
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue feeding the LEGv8 multicycle control unit.
// Owns the fetch PC, issues sequential word reads to a synchronous ROM,
// tracks requests in flight through a ROM_LATENCY-deep pipe and buffers
// returned instructions in a DEPTH-entry FIFO. A redirect flushes the queue
// and every in-flight request. Optional feature macro: PREFETCH_STATS_EN
// (flush and starvation counters).
module instr_prefetch_queue #(
    parameter int DEPTH       = 4,
    parameter int ROM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic              pipe_vld  [ROM_LATENCY];
    logic [ADDR_W-1:0] pipe_pc   [ROM_LATENCY];
    logic              issue;
    logic              push;
    logic              pop;
    int                inflight;
    logic              unused_pc_bits;

    // Credit check: a request may only go out if the queue can hold every
    // outstanding response; the pop of this cycle is deliberately not counted.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + (pipe_vld[i] ? 1 : 0);
        end
        issue = !reset && !bus.redirect && ((int'(count_q) + inflight) < DEPTH);
        push  = pipe_vld[ROM_LATENCY-1] && !bus.redirect;
        pop   = bus.fetch && (count_q != '0) && !bus.redirect;
    end

    assign bus.rom_req     = issue;
    assign bus.rom_addr    = fetch_pc;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = (count_q != '0) ? mem_instr[rd_ptr] : 32'h0;
    assign bus.instr_pc    = (count_q != '0) ? mem_pc[rd_ptr] : '0;
    assign bus.count       = count_q;
    assign unused_pc_bits  = ^bus.redirect_pc[1:0];

    // Fetch PC and in-flight pipe; a redirect restarts the PC and kills responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_pc[i]  <= '0;
            end
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
            end
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            pipe_vld[0] <= issue;
            pipe_pc[0]  <= fetch_pc;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_pc[i]  <= pipe_pc[i-1];
            end
        end
    end

    // Queue pointers and occupancy; a matured response lands at the tail.
    always_ff @(posedge clk) begin
        if (reset || bus.redirect) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; contents are only observable through a valid head entry.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_instr[wr_ptr] <= bus.rom_data;
            mem_pc[wr_ptr]    <= pipe_pc[ROM_LATENCY-1];
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] flush_q;
    logic [15:0] starve_q;

    // Saturating counters of redirects and of fetches that found no instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q  <= '0;
            starve_q <= '0;
        end else begin
            if (bus.redirect && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 1'b1;
            end
            if (bus.fetch && (count_q == '0) && (starve_q != 16'hFFFF)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    assign bus.flush_cnt  = flush_q;
    assign bus.starve_cnt = starve_q;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: a vector table for the
// start-up and streaming sequences, hand-written redirect/reset corner cases,
// and a randomized phase compared against a queue-based reference model.
module tb_instr_prefetch_queue;
    localparam int DEPTH       = 4;
    localparam int ROM_LATENCY = 1;
    localparam int ADDR_W      = 32;

    typedef struct {
        logic        rst;
        logic        fetch;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        int          due;
    } inf_t;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFail;
    int   cyc;

    ent_t        mq[$];
    inf_t        mi[$];
    logic [31:0] mPc;
    int          mFlush;
    int          mStarve;

    logic [31:0] romPipe [ROM_LATENCY];

    instr_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_prefetch_queue #(
        .DEPTH(DEPTH),
        .ROM_LATENCY(ROM_LATENCY),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[17:2]};
    endfunction

    // Synchronous ROM with ROM_LATENCY cycles of read latency
    always @(posedge clk) begin
        romPipe[0] <= rom_word(bus.rom_addr);
        for (int i = 1; i < ROM_LATENCY; i++) begin
            romPipe[i] <= romPipe[i-1];
        end
    end
    assign bus.rom_data = romPipe[ROM_LATENCY-1];

    function automatic vec_t mk(input logic r, input logic f, input logic d,
                                input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] ipc, input int cnt);
        vec_t t;
        t.rst = r; t.fetch = f; t.redir = d; t.rpc = rpc; t.req = req;
        t.addr = addr; t.valid = v; t.ipc = ipc; t.cnt = cnt;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s (cycle %0d): actual 0x%0h required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic d, input logic [31:0] rpc);
        @(negedge clk);
        reset           = r;
        bus.fetch       = f;
        bus.redirect    = d;
        bus.redirect_pc = rpc;
        #1;
    endtask

    // Reference model: next state from the rules, using plain queues
    task automatic modelStep();
        int  inflight;
        logic req;
        inflight = mi.size();
        req = !reset && !bus.redirect && ((mq.size() + inflight) < DEPTH);
        if (reset) begin
            mq.delete(); mi.delete(); mPc = 0; mFlush = 0; mStarve = 0;
        end else begin
            if (bus.fetch && mq.size() == 0 && mStarve < 16'hFFFF) mStarve++;
            if (bus.redirect) begin
                if (mFlush < 16'hFFFF) mFlush++;
                mq.delete(); mi.delete();
                mPc = bus.redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (bus.fetch && mq.size() > 0) void'(mq.pop_front());
                if (mi.size() > 0 && mi[0].due == cyc) begin
                    ent_t e;
                    e.pc = mi[0].pc;
                    e.instr = rom_word(mi[0].pc);
                    mq.push_back(e);
                    void'(mi.pop_front());
                end
                if (req) begin
                    inf_t n;
                    n.pc = mPc;
                    n.due = cyc + ROM_LATENCY;
                    mi.push_back(n);
                    mPc = mPc + 32'd4;
                end
            end
        end
    endtask

    task automatic advanceCycle();
        modelStep();
        @(posedge clk);
        cyc++;
    endtask

    task automatic checkModel();
        logic req;
        req = !reset && !bus.redirect && ((mq.size() + mi.size()) < DEPTH);
        checkOutput("rnd_req", 32'(bus.rom_req), 32'(req));
        checkOutput("rnd_addr", bus.rom_addr, mPc);
        checkOutput("rnd_valid", 32'(bus.instr_valid), 32'(mq.size() > 0));
        checkOutput("rnd_count", 32'(bus.count), 32'(mq.size()));
        if (mq.size() > 0) begin
            checkOutput("rnd_pc", bus.instr_pc, mq[0].pc);
            checkOutput("rnd_instr", bus.instr, mq[0].instr);
        end
`ifdef PREFETCH_STATS_EN
        checkOutput("rnd_flush_cnt", 32'(bus.flush_cnt), 32'(mFlush));
        checkOutput("rnd_starve_cnt", 32'(bus.starve_cnt), 32'(mStarve));
`endif
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            advanceCycle();
        end
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advanceCycle();
    endtask

    // Main test sequence
    initial begin
        vec_t tbl[$];
        nChecks = 0; nFail = 0; cyc = 0;
        mPc = 0; mFlush = 0; mStarve = 0;
        reset = 1'b1;
        bus.fetch = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

        // Reset state
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("reset_req", 32'(bus.rom_req), 32'h0);
        checkOutput("reset_addr", bus.rom_addr, 32'h0);
        checkOutput("reset_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("reset_instr", bus.instr, 32'h0);
        checkOutput("reset_pc", bus.instr_pc, 32'h0);
        checkOutput("reset_count", 32'(bus.count), 32'h0);
        advanceCycle();

        // Fill to full, reset while full, then stream with fetch held high
        tbl.push_back(mk(0,0,0,0, 1,32'h00, 0,32'h0, 0));
        tbl.push_back(mk(0,0,0,0, 1,32'h04, 0,32'h0, 0));
        tbl.push_back(mk(0,0,0,0, 1,32'h08, 1,32'h0, 1));
        tbl.push_back(mk(0,0,0,0, 1,32'h0C, 1,32'h0, 2));
        tbl.push_back(mk(0,0,0,0, 0,32'h10, 1,32'h0, 3));
        tbl.push_back(mk(0,0,0,0, 0,32'h10, 1,32'h0, 4));
        tbl.push_back(mk(0,0,0,0, 0,32'h10, 1,32'h0, 4));
        tbl.push_back(mk(1,0,0,0, 0,32'h10, 1,32'h0, 4));
        tbl.push_back(mk(0,1,0,0, 1,32'h00, 0,32'h0, 0));
        tbl.push_back(mk(0,1,0,0, 1,32'h04, 0,32'h0, 0));
        tbl.push_back(mk(0,1,0,0, 1,32'h08, 1,32'h0, 1));
        tbl.push_back(mk(0,1,0,0, 1,32'h0C, 1,32'h4, 1));
        tbl.push_back(mk(0,1,0,0, 1,32'h10, 1,32'h8, 1));
        tbl.push_back(mk(0,1,0,0, 1,32'h14, 1,32'hC, 1));
        tbl.push_back(mk(0,0,0,0, 1,32'h18, 1,32'h10, 1));
        tbl.push_back(mk(0,0,0,0, 1,32'h1C, 1,32'h10, 2));
        tbl.push_back(mk(0,0,0,0, 0,32'h20, 1,32'h10, 3));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].fetch, tbl[i].redir, tbl[i].rpc);
            checkOutput($sformatf("vec%0d_req", i), 32'(bus.rom_req), 32'(tbl[i].req));
            checkOutput($sformatf("vec%0d_addr", i), bus.rom_addr, tbl[i].addr);
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
            if (tbl[i].valid) begin
                checkOutput($sformatf("vec%0d_pc", i), bus.instr_pc, tbl[i].ipc);
                checkOutput($sformatf("vec%0d_instr", i), bus.instr, rom_word(tbl[i].ipc));
            end
            advanceCycle();
        end

        // Redirect with two entries queued and one request in flight
        resetDut();
        runCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h42);
        checkOutput("redir_count_before", 32'(bus.count), 32'd2);
        checkOutput("redir_req_forced", 32'(bus.rom_req), 32'h0);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_addr", bus.rom_addr, 32'h40);
        checkOutput("redir_req", 32'(bus.rom_req), 32'h1);
        checkOutput("redir_flushed", 32'(bus.count), 32'h0);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_stale_dropped", 32'(bus.count), 32'h0);
        checkOutput("redir_addr2", bus.rom_addr, 32'h44);
        advanceCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_first_valid", 32'(bus.instr_valid), 32'h1);
        checkOutput("redir_first_pc", bus.instr_pc, 32'h40);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_second_pc", bus.instr_pc, 32'h44);
        advanceCycle();

        // Redirect and fetch together with three entries queued
        resetDut();
        runCycles(4);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        checkOutput("redfetch_count_before", 32'(bus.count), 32'd3);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redfetch_count", 32'(bus.count), 32'h0);
        checkOutput("redfetch_addr", bus.rom_addr, 32'h100);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redfetch_valid_gap", 32'(bus.instr_valid), 32'h0);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redfetch_first_pc", bus.instr_pc, 32'h100);
        checkOutput("redfetch_first_valid", 32'(bus.instr_valid), 32'h1);
        advanceCycle();

        // Reset mid-operation with a request in flight
        resetDut();
        runCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("midreset_req", 32'(bus.rom_req), 32'h0);
        advanceCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("midreset_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("midreset_count", 32'(bus.count), 32'h0);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("midreset_restart_addr", bus.rom_addr, 32'h0);
        checkOutput("midreset_restart_req", 32'(bus.rom_req), 32'h1);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("midreset_stale_dropped", 32'(bus.count), 32'h0);
        advanceCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("midreset_first_pc", bus.instr_pc, 32'h0);
        checkOutput("midreset_first_count", 32'(bus.count), 32'h1);
        advanceCycle();

        // Randomized traffic against the reference model
        resetDut();
        for (int i = 0; i < 600; i++) begin
            logic r, f, d;
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 60);
            d = ($urandom_range(0, 99) < 6);
            applyStimulus(r, f, d, $urandom);
            checkModel();
            advanceCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
